// File: rtl/oflow_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oflow_mem_pkg: shared FSM state type and default geometry         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package oflow_mem_pkg;

  localparam int DATA_WIDTH_DEF = 284;
  localparam int ADDR_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_state_e;

endpackage
`default_nettype wire

// File: rtl/oflow_feature_bank_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oflow_feature_bank_ram: dual-port sync RAM bank, read latency 1   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module oflow_feature_bank_ram #(
  parameter int DATA_WIDTH = 284,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  a_en,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_en,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  always_ff @(posedge clk) begin
    if (a_en && a_we) mem[a_addr] <= a_wdata;
    if (b_en && b_we) mem[b_addr] <= b_wdata;
  end

  // Read registers only move on a read, so the last read word is held
  always_comb begin
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    if (a_en && !a_we) a_rdata_d = mem[a_addr];
    if (b_en && !b_we) b_rdata_d = mem[b_addr];
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule
`default_nettype wire

// File: rtl/oflow_feature_pingpong_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | oflow_feature_pingpong_mem: two-bank ping-pong feature row store  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module oflow_feature_pingpong_mem
  import oflow_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_N,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_pair,
  input  logic [DATA_WIDTH-1:0] wr_data_0,
  input  logic [DATA_WIDTH-1:0] wr_data_1,
  input  logic                  wr_frame_end,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr_0,
  input  logic [ADDR_WIDTH-1:0] rd_addr_1,
  input  logic                  rd_release,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data_0,
  output logic [DATA_WIDTH-1:0] rd_data_1,
  output logic                  rd_oob_0,
  output logic                  rd_oob_1,
  output logic                  rd_bank_valid,
  output logic [ADDR_WIDTH:0]   rd_row_count,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  wr_overflow
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(2 ** ADDR_WIDTH);

  fsm_state_e       state_q, state_d;
  logic             bank_sel_q, bank_sel_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d, wr_count_step;
  logic [CNT_W-1:0] rd_row_count_q, rd_row_count_d;
  logic             wr_overflow_q, wr_overflow_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_oob_0_q, rd_oob_0_d;
  logic             rd_oob_1_q, rd_oob_1_d;
  logic             rd_bank_q, rd_bank_d;

  logic swap;
  logic wr_ready_w, wr_fire, last_free, we_0, we_1, rd_fire;
  logic [ADDR_WIDTH-1:0] waddr_0, waddr_1;
  logic [DATA_WIDTH-1:0] bank_rdata_0 [2];
  logic [DATA_WIDTH-1:0] bank_rdata_1 [2];

  assign wr_ready_w = (wr_count_q != DEPTH_C) && (state_q != ST_HOLD);
  assign wr_fire    = wr_valid && wr_ready_w;
  assign last_free  = (wr_count_q == DEPTH_C - CNT_W'(1));
  // Gating with reset_N keeps the arrays untouched while reset is held
  assign we_0       = wr_fire && reset_N;
  assign we_1       = we_0 && wr_pair && !last_free;
  assign waddr_0    = wr_count_q[ADDR_WIDTH-1:0];
  assign waddr_1    = wr_count_q[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
  assign rd_fire    = rd_en && (state_q != ST_EMPTY);

  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (wr_frame_end) begin
          swap    = 1'b1;
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (wr_frame_end && rd_release) swap = 1'b1;
        else if (wr_frame_end)          state_d = ST_HOLD;
        else if (rd_release)            state_d = ST_EMPTY;
      end
      ST_HOLD: begin
        if (rd_release) begin
          swap    = 1'b1;
          state_d = ST_READY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    wr_count_step = wr_count_q;
    wr_overflow_d = wr_overflow_q;
    if (wr_fire) begin
      if (!wr_pair) begin
        wr_count_step = wr_count_q + CNT_W'(1);
      end else if (last_free) begin
        wr_count_step = DEPTH_C;
        wr_overflow_d = 1'b1;
      end else begin
        wr_count_step = wr_count_q + CNT_W'(2);
      end
    end
    // A swap captures the count including this cycle's write
    wr_count_d     = swap ? '0 : wr_count_step;
    rd_row_count_d = swap ? wr_count_step : rd_row_count_q;
    bank_sel_d     = bank_sel_q ^ swap;
  end

  // Reads use pre-swap bank and row count, so a swap-cycle read sees the old frame
  always_comb begin
    rd_valid_d = rd_fire;
    rd_oob_0_d = rd_oob_0_q;
    rd_oob_1_d = rd_oob_1_q;
    rd_bank_d  = rd_bank_q;
    if (rd_fire) begin
      rd_oob_0_d = ({1'b0, rd_addr_0} >= rd_row_count_q);
      rd_oob_1_d = ({1'b0, rd_addr_1} >= rd_row_count_q);
      rd_bank_d  = ~bank_sel_q;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q        <= ST_EMPTY;
      bank_sel_q     <= 1'b0;
      wr_count_q     <= '0;
      rd_row_count_q <= '0;
      wr_overflow_q  <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_oob_0_q     <= 1'b0;
      rd_oob_1_q     <= 1'b0;
      rd_bank_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bank_sel_q     <= bank_sel_d;
      wr_count_q     <= wr_count_d;
      rd_row_count_q <= rd_row_count_d;
      wr_overflow_q  <= wr_overflow_d;
      rd_valid_q     <= rd_valid_d;
      rd_oob_0_q     <= rd_oob_0_d;
      rd_oob_1_q     <= rd_oob_1_d;
      rd_bank_q      <= rd_bank_d;
    end
  end

  // bank_sel names the write bank; the other bank serves reads
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_wr;
    assign is_wr = (bank_sel_q == 1'(b));

    oflow_feature_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
      .clk     (clk),
      .reset_N (reset_N),
      .a_en    (is_wr ? we_0 : rd_fire),
      .a_we    (is_wr && we_0),
      .a_addr  (is_wr ? waddr_0 : rd_addr_0),
      .a_wdata (wr_data_0),
      .a_rdata (bank_rdata_0[b]),
      .b_en    (is_wr ? we_1 : rd_fire),
      .b_we    (is_wr && we_1),
      .b_addr  (is_wr ? waddr_1 : rd_addr_1),
      .b_wdata (wr_data_1),
      .b_rdata (bank_rdata_1[b])
    );
  end

  assign wr_ready      = wr_ready_w;
  assign wr_count      = wr_count_q;
  assign wr_overflow   = wr_overflow_q;
  assign rd_row_count  = rd_row_count_q;
  assign rd_bank_valid = (state_q != ST_EMPTY);
  assign rd_valid      = rd_valid_q;
  assign rd_oob_0      = rd_oob_0_q;
  assign rd_oob_1      = rd_oob_1_q;
  assign rd_data_0     = rd_oob_0_q ? '0 : bank_rdata_0[rd_bank_q];
  assign rd_data_1     = rd_oob_1_q ? '0 : bank_rdata_1[rd_bank_q];

endmodule
`default_nettype wire

// File: tb/tb_oflow_feature_pingpong_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_oflow_feature_pingpong_mem: directed vector bench, two sizes   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_oflow_feature_pingpong_mem;

  localparam int DW  = 284;
  localparam int AW  = 8;
  localparam int SDW = 16;
  localparam int SAW = 2;

  logic clk = 1'b0;
  logic reset_N = 1'b0;
  always #5 clk = ~clk;

  // Default-geometry instance
  logic          wr_valid = 0, wr_pair = 0, wr_frame_end = 0, rd_en = 0, rd_release = 0;
  logic [DW-1:0] wr_data_0 = '0, wr_data_1 = '0;
  logic [AW-1:0] rd_addr_0 = '0, rd_addr_1 = '0;
  logic          wr_ready, rd_valid, rd_oob_0, rd_oob_1, rd_bank_valid, wr_overflow;
  logic [DW-1:0] rd_data_0, rd_data_1;
  logic [AW:0]   rd_row_count, wr_count;

  // Four-row instance for the overflow corner
  logic           s_wv = 0, s_wp = 0, s_fe = 0, s_re = 0, s_rel = 0;
  logic [SDW-1:0] s_d0 = '0, s_d1 = '0;
  logic [SAW-1:0] s_a0 = '0, s_a1 = '0;
  logic           s_rdy, s_rv, s_o0, s_o1, s_bv, s_ovf;
  logic [SDW-1:0] s_q0, s_q1;
  logic [SAW:0]   s_rc, s_wc;

  oflow_feature_pingpong_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_N(reset_N),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pair(wr_pair),
    .wr_data_0(wr_data_0), .wr_data_1(wr_data_1), .wr_frame_end(wr_frame_end),
    .rd_en(rd_en), .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1), .rd_release(rd_release),
    .rd_valid(rd_valid), .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
    .rd_oob_0(rd_oob_0), .rd_oob_1(rd_oob_1), .rd_bank_valid(rd_bank_valid),
    .rd_row_count(rd_row_count), .wr_count(wr_count), .wr_overflow(wr_overflow)
  );

  oflow_feature_pingpong_mem #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW)) dut_s (
    .clk(clk), .reset_N(reset_N),
    .wr_valid(s_wv), .wr_ready(s_rdy), .wr_pair(s_wp),
    .wr_data_0(s_d0), .wr_data_1(s_d1), .wr_frame_end(s_fe),
    .rd_en(s_re), .rd_addr_0(s_a0), .rd_addr_1(s_a1), .rd_release(s_rel),
    .rd_valid(s_rv), .rd_data_0(s_q0), .rd_data_1(s_q1),
    .rd_oob_0(s_o0), .rd_oob_1(s_o1), .rd_bank_valid(s_bv),
    .rd_row_count(s_rc), .wr_count(s_wc), .wr_overflow(s_ovf)
  );

  typedef struct packed {
    logic          wv, wp;
    logic [DW-1:0] d0, d1;
    logic          fe, re;
    logic [AW-1:0] a0, a1;
    logic          rel;
  } vin_t;

  typedef struct packed {
    logic          rdy;
    logic [AW:0]   wc;
    logic          bv;
    logic [AW:0]   rc;
    logic          rv;
    logic [DW-1:0] d0, d1;
    logic          o0, o1, ovf;
  } exp_t;

  typedef struct packed {
    vin_t i;
    exp_t e;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Row code k>0 maps to a distinctive wide word; k=0 means all-zero
  function automatic logic [DW-1:0] kd(input int k);
    logic [DW-1:0] v;
    v = '0;
    if (k != 0) begin
      v[DW-1 -: 8] = 8'(k);
      v[31:0]      = 32'hC0DE_0000 + 32'(k);
    end
    return v;
  endfunction

  task automatic add(input int wv, wp, k0, k1, fe, re, a0, a1, rel,
                     input int rdy, wc, bv, rc, rv, e0, e1, o0, o1, ovf);
    vec_t v;
    v.i.wv = 1'(wv);  v.i.wp = 1'(wp);  v.i.d0 = kd(k0); v.i.d1 = kd(k1);
    v.i.fe = 1'(fe);  v.i.re = 1'(re);  v.i.a0 = AW'(a0); v.i.a1 = AW'(a1);
    v.i.rel = 1'(rel);
    v.e.rdy = 1'(rdy); v.e.wc = (AW+1)'(wc); v.e.bv = 1'(bv); v.e.rc = (AW+1)'(rc);
    v.e.rv = 1'(rv);  v.e.d0 = kd(e0); v.e.d1 = kd(e1);
    v.e.o0 = 1'(o0);  v.e.o1 = 1'(o1); v.e.ovf = 1'(ovf);
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input exp_t e);
    exp_t a;
    a.rdy = wr_ready; a.wc = wr_count; a.bv = rd_bank_valid; a.rc = rd_row_count;
    a.rv = rd_valid;  a.d0 = rd_data_0; a.d1 = rd_data_1;
    a.o0 = rd_oob_0;  a.o1 = rd_oob_1; a.ovf = wr_overflow;
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b wc=%0d bv=%b rc=%0d rv=%b oob=%b%b ovf=%b d0=%h d1=%h | want rdy=%b wc=%0d bv=%b rc=%0d rv=%b oob=%b%b ovf=%b d0=%h d1=%h",
               name, a.rdy, a.wc, a.bv, a.rc, a.rv, a.o0, a.o1, a.ovf, a.d0, a.d1,
               e.rdy, e.wc, e.bv, e.rc, e.rv, e.o0, e.o1, e.ovf, e.d0, e.d1);
    end
  endtask

  task automatic chk_v(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  exp_t rst_e;

  initial begin
    rst_e     = '0;
    rst_e.rdy = 1'b1;

    //   wv wp k0 k1 fe re a0 a1 rel | rdy wc bv rc rv e0 e1 o0 o1 ovf
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 2, 0, 0, 0, 0, 0,   1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 3, 4, 0, 0, 0, 0, 0,   1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 5, 6, 0, 0, 0, 0, 0,   1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 1, 6, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 4, 6, 0,   1, 0, 1, 6, 1, 5, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 6, 0, 5, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 5, 0,   1, 0, 1, 6, 1, 1, 6, 0, 0, 0);
    add(1, 0,11, 0, 0, 0, 0, 0, 0,   1, 1, 1, 6, 0, 1, 6, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 6, 0, 1, 6, 0, 0, 0);
    add(1, 0,12, 0, 1, 0, 0, 0, 0,   0, 1, 1, 6, 0, 1, 6, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 5, 1, 0,   0, 1, 1, 6, 1, 6, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 1, 0, 6, 2, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 1, 0,   1, 0, 1, 1, 1,11, 0, 0, 1, 0);
    add(1, 1,21,22, 0, 0, 0, 0, 0,   1, 2, 1, 1, 0,11, 0, 0, 1, 0);
    add(1, 1,23,24, 1, 1, 0, 1, 1,   1, 0, 1, 4, 1,11, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 3, 4, 0,   1, 0, 1, 4, 1,24, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 4, 0,24, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 4, 0,24, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0,24, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 1, 0, 0, 1, 1, 0);

    repeat (2) @(negedge clk);
    chk("in_reset", rst_e);
    reset_N = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      wr_valid = vq[i].i.wv;  wr_pair = vq[i].i.wp;
      wr_data_0 = vq[i].i.d0; wr_data_1 = vq[i].i.d1;
      wr_frame_end = vq[i].i.fe; rd_en = vq[i].i.re;
      rd_addr_0 = vq[i].i.a0; rd_addr_1 = vq[i].i.a1;
      rd_release = vq[i].i.rel;
      step();
      chk($sformatf("vec%0d", i), vq[i].e);
    end
    wr_valid = 0; wr_pair = 0; wr_frame_end = 0; rd_en = 0; rd_release = 0;

    // Four-row bank: three singles, then a pair with one free row
    for (int k = 0; k < 3; k++) begin
      s_wv = 1; s_wp = 0; s_d0 = SDW'(16'h0100 + k);
      step();
    end
    chk_v("s_wc_after_singles", 64'(s_wc), 64'd3);
    s_wp = 1; s_d0 = 16'h0103; s_d1 = 16'h01EE;
    step();
    chk_v("s_wc_after_pair", 64'(s_wc), 64'd4);
    chk_v("s_ovf_after_pair", 64'(s_ovf), 64'd1);
    chk_v("s_rdy_full", 64'(s_rdy), 64'd0);
    step();
    chk_v("s_wc_backpressure", 64'(s_wc), 64'd4);
    s_wv = 0; s_wp = 0; s_fe = 1;
    step();
    s_fe = 0;
    chk_v("s_rc_swap", 64'(s_rc), 64'd4);
    chk_v("s_wc_swap", 64'(s_wc), 64'd0);
    chk_v("s_rdy_swap", 64'(s_rdy), 64'd1);
    chk_v("s_ovf_sticky", 64'(s_ovf), 64'd1);
    s_re = 1; s_a0 = 2'd3; s_a1 = 2'd0;
    step();
    s_re = 0;
    chk_v("s_rv", 64'(s_rv), 64'd1);
    chk_v("s_row3", 64'(s_q0), 64'h0103);
    chk_v("s_row0", 64'(s_q1), 64'h0100);
    chk_v("s_oob", 64'({s_o0, s_o1}), 64'd0);

    // Asynchronous reset in the middle of a write frame
    wr_valid = 1; wr_pair = 1; wr_data_0 = kd(31); wr_data_1 = kd(32);
    @(posedge clk);
    #2;
    chk_v("pre_reset_wc", 64'(wr_count), 64'd2);
    reset_N = 1'b0;
    #1;
    chk("async_reset", rst_e);
    chk_v("s_async_ovf", 64'(s_ovf), 64'd0);
    chk_v("s_async_rc", 64'(s_rc), 64'd0);
    chk_v("s_async_bv", 64'(s_bv), 64'd0);
    step();
    chk("reset_held_write", rst_e);
    wr_valid = 0; wr_pair = 0;
    reset_N = 1'b1;
    step();
    chk("after_reset", rst_e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/oflow_feature_pingpong_mem.md
OFLOW_FEATURE_PINGPONG_MEM -- requirements
Module: oflow_feature_pingpong_mem

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 284, meaning the feature row width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the row address width; DEPTH = 2**ADDR_WIDTH rows per bank.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset, with ports: clk  in  1  clock; reset_N  in  1  async active-low reset.
REQ-004 The block SHALL have these write ports: wr_valid in 1 (write request); wr_ready out 1 (write accepted); wr_pair in 1 (write two rows); wr_data_0 in DATA_WIDTH (row at wr_count); wr_data_1 in DATA_WIDTH (row at wr_count+1); wr_frame_end in 1 (pulse, closes the write frame).
REQ-005 The block SHALL have these read ports: rd_en in 1; rd_addr_0 in ADDR_WIDTH; rd_addr_1 in ADDR_WIDTH; rd_release in 1 (pulse, consumer done with read bank).
REQ-006 The block SHALL have these status and data outputs: rd_valid out 1; rd_data_0 out DATA_WIDTH; rd_data_1 out DATA_WIDTH; rd_oob_0 out 1; rd_oob_1 out 1; rd_bank_valid out 1; rd_row_count out ADDR_WIDTH+1; wr_count out ADDR_WIDTH+1; wr_overflow out 1 (sticky).

Function
REQ-007 The block SHALL hold two banks of DEPTH x DATA_WIDTH: one write bank and one read bank, selected by a 1-bit bank_sel register.
REQ-008 Write accept SHALL be wr_valid & wr_ready, writing wr_data_0 at wr_count and, if wr_pair, wr_data_1 at wr_count+1.
REQ-009 On each accepted write, wr_count SHALL advance by 1 (single) or 2 (pair), saturating at DEPTH.
REQ-010 wr_ready SHALL be 0 when wr_count==DEPTH or the FSM is in HOLD, and 1 otherwise.
REQ-011 An accepted pair with exactly one free row SHALL write row 0 only, drop row 1, set wr_overflow, and advance wr_count to DEPTH.
REQ-012 wr_overflow SHALL be cleared only by reset; backpressure (wr_valid while wr_ready=0) SHALL NOT set it.
REQ-013 The FSM SHALL have states EMPTY (no readable bank), READY (read bank valid), and HOLD (write frame closed, awaiting release).
REQ-014 In EMPTY, wr_frame_end SHALL trigger a swap and move the FSM to READY.
REQ-015 In READY, wr_frame_end with rd_release in the same cycle SHALL trigger a swap and keep the FSM in READY.
REQ-016 In READY, wr_frame_end without rd_release SHALL move the FSM to HOLD.
REQ-017 In READY, rd_release alone SHALL move the FSM to EMPTY.
REQ-018 In HOLD, rd_release SHALL trigger a swap and move the FSM to READY; wr_frame_end in HOLD SHALL be ignored.
REQ-019 A swap SHALL toggle bank_sel, load rd_row_count from the final wr_count (including any write accepted that same cycle), and clear wr_count to 0.
REQ-020 A frame with zero rows SHALL still swap, giving rd_row_count=0.
REQ-021 rd_bank_valid SHALL be 1 in READY and HOLD, and 0 in EMPTY.
REQ-022 rd_en with rd_bank_valid=1 SHALL read both addresses from the read bank, with rd_valid and data appearing exactly 1 cycle later.
REQ-023 rd_en with rd_bank_valid=0 SHALL be ignored, leaving rd_valid at 0.
REQ-024 When rd_addr_n >= rd_row_count, rd_data_n SHALL be all-zero and rd_oob_n=1, aligned with rd_valid.
REQ-025 A read issued in a swap cycle SHALL return data from the pre-swap read bank.
REQ-026 rd_data_0/1 and rd_oob_0/1 SHALL hold their last values while rd_valid=0.

Reset
REQ-027 Reset assertion SHALL asynchronously force FSM=EMPTY, bank_sel=0, wr_count=0, rd_row_count=0, rd_valid=0, rd_oob_0/1=0, rd_data_0/1=0, wr_overflow=0, and therefore wr_ready=1 and rd_bank_valid=0; memory contents are undefined.
REQ-028 Reset asserted mid-frame SHALL discard all frames; no write SHALL occur while reset_N=0.

Structure
REQ-029 The shared package oflow_mem_pkg SHALL hold the FSM state enum and default DATA_WIDTH/ADDR_WIDTH constants.
REQ-030 Each bank SHALL be one instance of sub-module oflow_feature_bank_ram (two synchronous read/write ports, read latency 1), instantiated twice.

Verification
REQ-031 The bench SHALL cover: reset, 3 pair writes (rows 0-5), frame_end -> rd_bank_valid=1, rd_row_count=6, wr_count=0.
REQ-032 The bench SHALL cover: rd_en with addr 4/6 -> 1 cycle later rd_valid=1, rd_data_0=row4, rd_data_1=0, rd_oob_1=1.
REQ-033 The bench SHALL cover: ADDR_WIDTH=2, 3 single writes, then a pair -> row 3 written, wr_count=4, wr_overflow=1, wr_ready=0.
REQ-034 The bench SHALL cover: frame_end in READY without release -> HOLD, wr_ready=0; rd_release -> swap, wr_ready=1, new rd_row_count.
REQ-035 The bench SHALL cover: frame_end, rd_release and rd_en in the same cycle -> read returns pre-swap bank data; FSM stays READY.
REQ-036 The bench SHALL cover: reset_N pulled low mid-write -> all outputs reach reset values immediately, without a clock edge.
